// File: rtl/uart_lb_pkg.sv
// uart_lb_pkg: shared types and constants for the UART loopback controller.
//   lb_state_e   - transmit handshake FSM states
//   TERM_DEFAULT - default line terminator (LF)
//   DropCntW     - width of the saturating drop counter
package uart_lb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } lb_state_e;

  localparam logic [7:0] TERM_DEFAULT = 8'h0A;
  localparam int         DropCntW     = 16;

endpackage

// File: rtl/uart_lb_fifo.sv
// uart_lb_fifo: Width x Depth circular buffer with occupancy counter.
//   i_clk, i_rst_n   clock, async active-low reset
//   i_wr, i_wr_data  write request; ignored when o_full (pre-edge value)
//   i_rd             read request; ignored when o_empty
//   o_rd_data        word at the read pointer (combinational)
//   o_level          occupancy 0..Depth
//   o_empty, o_full  derived from the registered level
// Depth must be a power of two so pointers wrap by natural overflow.
module uart_lb_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16,
  parameter int AddrW = $clog2(Depth),
  parameter int LvlW  = $clog2(Depth) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [Width-1:0] i_wr_data,
  input  logic             i_rd,
  output logic [Width-1:0] o_rd_data,
  output logic [LvlW-1:0]  o_level,
  output logic             o_empty,
  output logic             o_full
);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  // Full/empty come from the registered level, so a read in the same
  // cycle never rescues a write attempted at full.
  assign o_empty   = (o_level == '0);
  assign o_full    = (o_level == LvlW'(Depth));
  assign wr_en     = i_wr & ~o_full;
  assign rd_en     = i_rd & ~o_empty;
  assign o_rd_data = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   o_level <= o_level + 1'b1;
        2'b01:   o_level <= o_level - 1'b1;
        default: o_level <= o_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_loopback_ctrl.sv
// uart_loopback_ctrl: buffers words from a UART receiver and drains them to
// a UART transmitter with a strobe/busy handshake.
//   i_clk, i_rst_n     clock, async active-low reset
//   i_rx_valid/byte    one-cycle receive strobe and word
//   i_tx_busy          transmitter busy
//   i_line_mode        1 = only drain once a complete line is buffered
//   o_tx_enable/byte   one-cycle transmit strobe; byte held until next issue
//   o_level            FIFO occupancy; o_empty/o_full/o_almost_full flags
//   o_drop_count       saturating count of words lost at full
// Optional: define UART_LB_UPCASE_EN to convert a..z to A..Z on the way out
// (Width==8 only). Line detection always uses the stored word.
module uart_loopback_ctrl
  import uart_lb_pkg::*;
#(
  parameter int               Width      = 8,
  parameter int               Depth      = 16,
  parameter int               AfThresh   = 12,
  parameter logic [Width-1:0] Terminator = Width'(TERM_DEFAULT),
  parameter int               AckTimeout = 4,
  parameter int               LvlW       = $clog2(Depth) + 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rx_valid,
  input  logic [Width-1:0]    i_rx_byte,
  input  logic                i_tx_busy,
  input  logic                i_line_mode,
  output logic                o_tx_enable,
  output logic [Width-1:0]    o_tx_byte,
  output logic [LvlW-1:0]     o_level,
  output logic                o_empty,
  output logic                o_full,
  output logic                o_almost_full,
  output logic [DropCntW-1:0] o_drop_count
);

  localparam int              TmrW  = $clog2(AckTimeout + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(AckTimeout - 1);
  localparam logic [LvlW-1:0] AfLvl = LvlW'(AfThresh);

  lb_state_e        state_q, state_d;
  logic [TmrW-1:0]  timer_q;
  logic [LvlW-1:0]  line_cnt;
  logic [Width-1:0] rd_data, tx_word;
  logic             drain_ok, issue, wr_ok, term_in, term_out;

  uart_lb_fifo #(.Width(Width), .Depth(Depth)) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr      (i_rx_valid),
    .i_wr_data (i_rx_byte),
    .i_rd      (issue),
    .o_rd_data (rd_data),
    .o_level   (o_level),
    .o_empty   (o_empty),
    .o_full    (o_full)
  );

  assign o_almost_full = (o_level >= AfLvl);
  assign wr_ok         = i_rx_valid & ~o_full;

  // Full without a terminator still drains, otherwise line mode deadlocks.
  assign drain_ok = ~o_empty & (~i_line_mode | (line_cnt != '0) | o_full);

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (drain_ok && !i_tx_busy) state_d = ISSUE;
      ISSUE:     state_d = WAIT_ACK;
      // A strobe the transmitter never acknowledges is abandoned, not resent.
      WAIT_ACK:  if (i_tx_busy)              state_d = WAIT_DONE;
                 else if (timer_q == TmrLast) state_d = IDLE;
      WAIT_DONE: if (!i_tx_busy)             state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM: outputs (the pop is taken on the IDLE->ISSUE edge)
  always_comb begin
    issue = (state_q == IDLE) & drain_ok & ~i_tx_busy;
  end

  always_comb begin
    tx_word = rd_data;
`ifdef UART_LB_UPCASE_EN
    if (Width == 8 && rd_data >= Width'(8'h61) && rd_data <= Width'(8'h7A))
      tx_word = rd_data - Width'(8'h20);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_enable <= 1'b0;
      o_tx_byte   <= '0;
      timer_q     <= '0;
    end else begin
      o_tx_enable <= issue;
      if (issue) o_tx_byte <= tx_word;
      timer_q <= (state_q == WAIT_ACK) ? timer_q + 1'b1 : '0;
    end
  end

  assign term_in  = wr_ok & (i_rx_byte == Terminator);
  assign term_out = issue & (rd_data == Terminator);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_cnt     <= '0;
      o_drop_count <= '0;
    end else begin
      case ({term_in, term_out})
        2'b10:   line_cnt <= line_cnt + 1'b1;
        2'b01:   line_cnt <= line_cnt - 1'b1;
        default: line_cnt <= line_cnt;
      endcase
      if (i_rx_valid && o_full && o_drop_count != '1)
        o_drop_count <= o_drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// tb_uart_loopback_ctrl: directed bench for uart_loopback_ctrl with default
// parameters. A behavioural transmitter drives i_tx_busy; a monitor logs
// every strobe (word and cycle) for ordering and timing checks.
module tb_uart_loopback_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_byte = '0;
  logic        i_tx_busy = 1'b0;
  logic        i_line_mode = 1'b0;
  logic        o_tx_enable;
  logic [7:0]  o_tx_byte;
  logic [4:0]  o_level;
  logic        o_empty, o_full, o_almost_full;
  logic [15:0] o_drop_count;

  uart_loopback_ctrl dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rx_valid    (i_rx_valid),
    .i_rx_byte     (i_rx_byte),
    .i_tx_busy     (i_tx_busy),
    .i_line_mode   (i_line_mode),
    .o_tx_enable   (o_tx_enable),
    .o_tx_byte     (o_tx_byte),
    .o_level       (o_level),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .o_drop_count  (o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  int         n_chk = 0, n_pass = 0;
  int         cyc = 0;
  int         busy_mode = 0;  // 0 auto, 1 held high, 2 held low
  int         busy_len = 2;
  int         busy_cnt = 0;
  int         b2b = 0;
  logic       prev_en = 1'b0;
  logic [7:0] txq[$];
  int         tcyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_tx(input logic [7:0] b);
`ifdef UART_LB_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Strobe monitor and transmitter model: busy rises the cycle after a
  // strobe and stays up for busy_len cycles.
  initial forever begin
    @(negedge i_clk);
    if (i_rst_n && o_tx_enable) begin
      txq.push_back(o_tx_byte);
      tcyc.push_back(cyc);
    end
    if (o_tx_enable && prev_en) b2b++;
    prev_en = o_tx_enable;
    case (busy_mode)
      1: i_tx_busy = 1'b1;
      2: i_tx_busy = 1'b0;
      default: begin
        if (busy_cnt > 0) begin
          i_tx_busy = 1'b1;
          busy_cnt--;
        end else begin
          i_tx_busy = 1'b0;
        end
        if (o_tx_enable) busy_cnt = busy_len;
      end
    endcase
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wr(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_valid = 1'b1;
    i_rx_byte  = b;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic wr_burst(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_rx_valid = 1'b1;
      i_rx_byte  = base + 8'(i);
    end
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic clr_log();
    txq.delete();
    tcyc.delete();
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_level", o_level, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_af", o_almost_full, 0);
    chk("rst_txen", o_tx_enable, 0);
    chk("rst_txbyte", o_tx_byte, 0);
    chk("rst_drop", o_drop_count, 0);
    wait_cyc(2);
    i_rst_n = 1'b1;
    wait_cyc(2);

    // Stream mode single word: strobe one cycle after the write edge
    clr_log();
    wr(8'h41);
    chk("lat_txen_k", o_tx_enable, 0);
    chk("lat_level_k", o_level, 1);
    @(negedge i_clk);
    chk("lat_txen_k1", o_tx_enable, 1);
    chk("lat_txbyte", o_tx_byte, 8'h41);
    chk("lat_level_k1", o_level, 0);
    wait_cyc(10);
    chk("lat_nstrobe", txq.size(), 1);
    chk("lat_hold", o_tx_byte, 8'h41);

    // Fill past full with transmitter held busy
    busy_mode = 1;
    wait_cyc(2);
    clr_log();
    for (int i = 0; i < 18; i++) begin
      @(negedge i_clk);
      if (i == 11) begin
        chk("fill_lvl11", o_level, 11);
        chk("fill_af11", o_almost_full, 0);
      end
      if (i == 12) chk("fill_af12", o_almost_full, 1);
      if (i == 17) chk("fill_drop1", o_drop_count, 1);
      i_rx_valid = 1'b1;
      i_rx_byte  = 8'h10 + 8'(i);
    end
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    chk("fill_level", o_level, 16);
    chk("fill_full", o_full, 1);
    chk("fill_af", o_almost_full, 1);
    chk("fill_drop", o_drop_count, 2);
    chk("fill_nostrobe", txq.size(), 0);

    // Release the transmitter and drain
    busy_mode = 0;
    wait_cyc(150);
    chk("drain_cnt", txq.size(), 16);
    if (txq.size() == 16) begin
      chk("drain_first", txq[0], 8'h10);
      chk("drain_last", txq[15], 8'h1F);
    end
    chk("drain_empty", o_empty, 1);
    chk("drain_drop", o_drop_count, 2);

    // Line mode: nothing leaves until the terminator arrives
    i_line_mode = 1'b1;
    clr_log();
    wr(8'h61);
    wr(8'h62);
    wait_cyc(8);
    chk("line_hold_cnt", txq.size(), 0);
    chk("line_hold_lvl", o_level, 2);
    wr(8'h0A);
    wait_cyc(40);
    chk("line_cnt", txq.size(), 3);
    if (txq.size() == 3) begin
      chk("line_b0", txq[0], exp_tx(8'h61));
      chk("line_b1", txq[1], exp_tx(8'h62));
      chk("line_b2", txq[2], 8'h0A);
    end
    chk("line_lvl0", o_level, 0);

    // Line count back to zero: a lone word stays put
    clr_log();
    wr(8'h63);
    wait_cyc(15);
    chk("line_nocnt", txq.size(), 0);
    wr_burst(8'h30, 14);
    wait_cyc(3);
    chk("force_lvl15", o_level, 15);
    chk("force_none", txq.size(), 0);
    wr(8'h3E);
    wait_cyc(20);
    chk("force_one", txq.size(), 1);
    if (txq.size() >= 1) chk("force_b0", txq[0], exp_tx(8'h63));
    chk("force_lvl", o_level, 15);
    wr(8'h0A);
    wait_cyc(150);
    chk("force_total", txq.size(), 17);
    if (txq.size() == 17) begin
      chk("force_b1", txq[1], 8'h30);
      chk("force_last", txq[16], 8'h0A);
    end
    chk("force_empty", o_empty, 1);

    // Ack timeout: busy never rises, second word follows 6 cycles later
    i_line_mode = 1'b0;
    busy_mode = 2;
    wait_cyc(2);
    clr_log();
    wr_burst(8'h51, 2);
    wait_cyc(20);
    chk("tmo_cnt", txq.size(), 2);
    if (txq.size() == 2) begin
      chk("tmo_gap", tcyc[1] - tcyc[0], 6);
      chk("tmo_b1", txq[1], 8'h52);
    end
    chk("tmo_empty", o_empty, 1);

    // Case conversion boundaries
    busy_mode = 0;
    busy_len = 2;
    clr_log();
    wr_burst(8'h60, 2);
    wr_burst(8'h7A, 2);
    wait_cyc(40);
    chk("up_cnt", txq.size(), 4);
    if (txq.size() == 4) begin
      chk("up_60", txq[0], exp_tx(8'h60));
      chk("up_61", txq[1], exp_tx(8'h61));
      chk("up_7a", txq[2], exp_tx(8'h7A));
      chk("up_7b", txq[3], exp_tx(8'h7B));
    end

    // Reset while in WAIT_DONE with 5 words buffered
    busy_len = 50;
    clr_log();
    wr_burst(8'h01, 6);
    wait_cyc(3);
    chk("mid_lvl", o_level, 5);
    chk("mid_busy_strobes", txq.size(), 1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    busy_mode = 2;
    #1;
    chk("mrst_level", o_level, 0);
    chk("mrst_empty", o_empty, 1);
    chk("mrst_full", o_full, 0);
    chk("mrst_txen", o_tx_enable, 0);
    chk("mrst_txbyte", o_tx_byte, 0);
    chk("mrst_drop", o_drop_count, 0);
    wait_cyc(2);
    i_rst_n = 1'b1;
    clr_log();
    wait_cyc(20);
    chk("mrst_nostrobe", txq.size(), 0);
    chk("mrst_lvl", o_level, 0);

    chk("no_back2back", b2b, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
